// File: rtl/hier_inv_checker.sv
// hier_inv_checker: drives LFSR stimulus into an inverting DUT and checks its response.
// Define HIER_INV_CHK_ERRCNT_EN for a saturating 16-bit mismatch count on err_count.
module hier_inv_checker #(
    parameter type         TYPE_STIM   = logic [31:0],
    parameter type         TYPE_RESP   = logic [31:0],
    parameter int unsigned NUM_VECTORS = 16,
    parameter int unsigned LATENCY     = 0,
    parameter logic [31:0] SEED        = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output TYPE_STIM    stim,
    input  TYPE_RESP    resp,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count
);
    localparam int          SW       = $bits(TYPE_STIM);
    localparam int          RW       = $bits(TYPE_RESP);
    localparam int          LW       = (SW > 32) ? SW : 32;
    localparam int          XW       = (SW > RW) ? SW : RW;
    localparam int          DL       = (LATENCY > 0) ? int'(LATENCY) : 1;
    localparam logic [31:0] MASK     = 32'h8020_0003;
    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? MASK : 32'd0);
    endfunction

    function automatic logic [SW-1:0] to_sw(input logic [31:0] s);
        logic [LW-1:0] w;
        w = LW'(s);
        return w[SW-1:0];
    endfunction

    // Cast to the response width first, then invert.
    function automatic logic [RW-1:0] inv_rw(input logic [SW-1:0] s);
        logic [XW-1:0] w;
        w = XW'(s);
        return ~w[RW-1:0];
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    state_t        state;
    logic [31:0]   lfsr;
    logic [15:0]   vec_cnt;
    logic [3:0]    drain_cnt;
    logic [SW-1:0] stim_p0;
    logic [RW-1:0] resp_bits;
    logic [RW-1:0] exp_cmp;
    logic          vld_cmp;
    logic          mism;

    assign stim      = stim_p0;
    assign resp_bits = resp;
    assign mism      = vld_cmp && (resp_bits !== exp_cmp);

    generate
        if (LATENCY == 0) begin : g_comb
            assign exp_cmp = inv_rw(stim_p0);
            assign vld_cmp = (state == RUN);
        end else begin : g_pipe
            logic [RW-1:0]      exp_p [LATENCY];
            logic [LATENCY-1:0] vld_p;

            // Expected-value delay line, stage 0 captures the driven vector
            always_ff @(posedge clk) begin
                exp_p[0] <= inv_rw(stim_p0);
                for (int i = 1; i < int'(LATENCY); i++) exp_p[i] <= exp_p[i-1];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) vld_p <= '0;
                else     vld_p <= LATENCY'({vld_p, state == RUN});
            end

            assign exp_cmp = exp_p[LATENCY-1];
            assign vld_cmp = vld_p[LATENCY-1];
        end
    endgenerate

`ifdef HIER_INV_CHK_ERRCNT_EN
    logic [15:0] err_q;
    logic [15:0] err_nxt;
    assign err_nxt   = mism ? sat_inc(err_q) : err_q;
    assign err_count = err_q;
`else
    logic err_q;
    logic err_nxt;
    assign err_nxt   = err_q | mism;
    assign err_count = 16'd0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lfsr      <= SEED_EFF;
            vec_cnt   <= '0;
            drain_cnt <= '0;
            stim_p0   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_q     <= '0;
        end else begin
            err_q <= err_nxt;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= RUN;
                        stim_p0 <= to_sw(SEED_EFF);
                        lfsr    <= lfsr_next(SEED_EFF);
                        vec_cnt <= 16'd1;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        pass    <= 1'b0;
                        err_q   <= '0;
                    end
                end
                RUN: begin
                    if (vec_cnt == 16'(NUM_VECTORS)) begin
                        stim_p0 <= '0;
                        if (LATENCY == 0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_nxt == '0);
                        end else begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end
                    end else begin
                        stim_p0 <= to_sw(lfsr);
                        lfsr    <= lfsr_next(lfsr);
                        vec_cnt <= vec_cnt + 16'd1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 4'(DL - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_nxt == '0);
                    end else begin
                        drain_cnt <= drain_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hier_inv_checker.sv
// Directed bench for hier_inv_checker: combinational, narrow-response pipelined and long saturating runs.
module tb_hier_inv_checker;
    logic        clk;
    logic        rst_a, rst_b;
    logic        start0, start1, start2;
    logic        inj0, inj1_en, sel2;

    logic [31:0] stim0, resp0;
    logic        busy0, done0, pass0;
    logic [15:0] err0;

    logic [31:0] stim1;
    logic [7:0]  resp1, d1, d2, d3;
    logic        busy1, done1, pass1;
    logic [15:0] err1;

    logic [31:0] stim2, resp2;
    logic        busy2, done2, pass2;
    logic [15:0] err2;

    int          n_cmp, n_err;
    logic [31:0] vec [16];

`ifdef HIER_INV_CHK_ERRCNT_EN
    localparam logic [31:0] ERR_ONE = 32'd1;
    localparam logic [31:0] ERR_SAT = 32'd65535;
`else
    localparam logic [31:0] ERR_ONE = 32'd0;
    localparam logic [31:0] ERR_SAT = 32'd0;
`endif

    hier_inv_checker #(.NUM_VECTORS(16), .LATENCY(0)) u0 (
        .clk(clk), .rst(rst_a), .start(start0), .stim(stim0), .resp(resp0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0));

    hier_inv_checker #(.TYPE_RESP(logic [7:0]), .NUM_VECTORS(16), .LATENCY(3)) u1 (
        .clk(clk), .rst(rst_b), .start(start1), .stim(stim1), .resp(resp1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1));

    hier_inv_checker #(.NUM_VECTORS(65535), .LATENCY(0)) u2 (
        .clk(clk), .rst(rst_b), .start(start2), .stim(stim2), .resp(resp2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inverting DUT models: u0 combinational, u1 three-stage pipeline (two-stage when sel2)
    assign resp0 = ~stim0 ^ {31'd0, inj0};
    assign resp2 = 32'd0;
    always @(posedge clk) begin
        d1 <= ~stim1[7:0] ^ {7'd0, inj1_en && (stim1 == 32'h6018_0001)};
        d2 <= d1;
        d3 <= d2;
    end
    assign resp1 = sel2 ? d2 : d3;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_u0(input string tag, input int inj_k, input int dup_k);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("%s_stim%0d", tag, k), stim0, vec[k]);
            chk($sformatf("%s_busy%0d", tag, k), {31'd0, busy0}, 32'd1);
            if (k == 1) chk($sformatf("%s_v1_hand", tag), stim0, 32'h8020_0003);
            inj0   = (k == inj_k);
            start0 = (k == dup_k);
            tick();
        end
        inj0   = 1'b0;
        start0 = 1'b0;
        chk({tag, "_busy_end"}, {31'd0, busy0}, 32'd0);
        chk({tag, "_done"},     {31'd0, done0}, 32'd1);
        chk({tag, "_stim_idle"}, stim0, 32'd0);
    endtask

    task automatic run_u1(output int n);
        int c;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n = 0;
        c = 0;
        while (busy1 === 1'b1 && c < 60) begin
            n++;
            c++;
            tick();
        end
        chk("u1_done", {31'd0, done1}, 32'd1);
    endtask

    initial begin
        int n;
        int c;
        n_cmp = 0;
        n_err = 0;
        rst_a = 1'b1; rst_b = 1'b1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        inj0 = 1'b0; inj1_en = 1'b0; sel2 = 1'b0;
        vec[0] = 32'h1;
        for (int i = 1; i < 16; i++)
            vec[i] = (vec[i-1] >> 1) ^ (vec[i-1][0] ? 32'h8020_0003 : 32'd0);

        repeat (3) tick();
        chk("rst_stim",  stim0, 32'd0);
        chk("rst_busy",  {31'd0, busy0}, 32'd0);
        chk("rst_done",  {31'd0, done0}, 32'd0);
        chk("rst_pass",  {31'd0, pass0}, 32'd0);
        chk("rst_err",   {16'd0, err0}, 32'd0);
        chk("rst_busy1", {31'd0, busy1}, 32'd0);
        rst_a = 1'b0; rst_b = 1'b0;
        tick();

        start2 = 1'b1;
        tick();
        start2 = 1'b0;

        // Clean run with an ignored mid-run start, then back-to-back faulty run
        run_u0("r1", -1, 5);
        chk("r1_pass", {31'd0, pass0}, 32'd1);
        chk("r1_err",  {16'd0, err0}, 32'd0);
        run_u0("r2", 3, -1);
        chk("r2_pass", {31'd0, pass0}, 32'd0);
        chk("r2_err",  {16'd0, err0}, ERR_ONE);

        // Asynchronous abort in RUN cycle 5
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        inj0 = 1'b1;
        tick();
        inj0 = 1'b0;
        repeat (3) tick();
        chk("pre_rst_busy", {31'd0, busy0}, 32'd1);
        #2;
        rst_a = 1'b1;
        #1;
        chk("abort_stim", stim0, 32'd0);
        chk("abort_busy", {31'd0, busy0}, 32'd0);
        chk("abort_done", {31'd0, done0}, 32'd0);
        chk("abort_pass", {31'd0, pass0}, 32'd0);
        chk("abort_err",  {16'd0, err0}, 32'd0);
        tick();
        rst_a = 1'b0;
        tick();
        run_u0("r3", -1, -1);
        chk("r3_pass", {31'd0, pass0}, 32'd1);
        chk("r3_err",  {16'd0, err0}, 32'd0);

        // Narrow response with latency 3
        run_u1(n);
        chk("u1_busy_len", n, 32'd19);
        chk("u1_pass", {31'd0, pass1}, 32'd1);
        chk("u1_err",  {16'd0, err1}, 32'd0);
        inj1_en = 1'b1;
        run_u1(n);
        inj1_en = 1'b0;
        chk("u1_inj_pass", {31'd0, pass1}, 32'd0);
        chk("u1_inj_err",  {16'd0, err1}, ERR_ONE);
        sel2 = 1'b1;
        run_u1(n);
        sel2 = 1'b0;
        chk("u1_lat2_pass", {31'd0, pass1}, 32'd0);
`ifdef HIER_INV_CHK_ERRCNT_EN
        chk("u1_lat2_err_nz", {31'd0, err1 != 16'd0}, 32'd1);
`else
        chk("u1_lat2_err", {16'd0, err1}, 32'd0);
`endif

        // Long run against a stuck-at-zero response
        c = 0;
        while (done2 !== 1'b1 && c < 70000) begin
            tick();
            c++;
        end
        chk("u2_done", {31'd0, done2}, 32'd1);
        chk("u2_busy", {31'd0, busy2}, 32'd0);
        chk("u2_pass", {31'd0, pass2}, 32'd0);
        chk("u2_err",  {16'd0, err2}, ERR_SAT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
